// File: rtl/wb_irq_ctrl.sv
// wb_irq_ctrl: Wishbone interrupt controller with level/edge sources, enable mask and claim/complete handshake
module wb_irq_ctrl #(
  parameter int N_SRC         = 8,
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  input  logic [N_SRC-1:0]         irq_src_i,
  output logic                     irq_o
);
  typedef enum logic {IDLE, CLAIMED} state_t;
  state_t state, state_n;
  logic [5:0] claimed_id, claimed_n, cand;
  logic [N_SRC-1:0] src_q, pending, enable, edge_mode, pe, wmask, set, clr, edge_chg;
  logic primed, acc, wr, rd, take;
  logic [2:0] idx;
  logic [WB_DATA_WIDTH-1:0] rdata;
  logic unused;
  assign unused   = ^{wb_sel_i, wb_addr_i, wb_data_i};
  assign acc      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign idx      = wb_addr_i[4:2];
  assign wr       = acc & wb_we_i;
  assign rd       = acc & ~wb_we_i;
  assign wmask    = wb_data_i[N_SRC-1:0];
  assign pe       = pending & enable;
  // primed masks the first post-reset cycle so a source held high through reset is not seen as an edge
  assign set      = primed ? (irq_src_i & ~src_q) : '0;
  assign clr      = ((wr && idx == 3'd0) ? wmask : '0) | (take ? (N_SRC'(1) << (cand - 6'd1)) : '0);
  assign edge_chg = (wr && idx == 3'd2) ? (wmask ^ edge_mode) : '0;
  always_comb begin
    cand = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (pe[i]) cand = 6'(i + 1);
  end
  always_comb begin
    state_n   = state;
    claimed_n = claimed_id;
    take      = 1'b0;
    if (state == IDLE) begin
      if (rd && idx == 3'd3 && cand != '0) begin
        state_n   = CLAIMED;
        claimed_n = cand;
        take      = 1'b1;
      end
    end else if (wr && idx == 3'd4 && wb_data_i == WB_DATA_WIDTH'(claimed_id)) begin
      state_n   = IDLE;
      claimed_n = '0;
    end
  end
  always_comb begin
    rdata = '0;
    case (idx)
      3'd0: rdata[N_SRC-1:0] = pending;
      3'd1: rdata[N_SRC-1:0] = enable;
      3'd2: rdata[N_SRC-1:0] = edge_mode;
      3'd3: rdata[5:0] = (state == IDLE) ? cand : claimed_id;
      3'd5: begin
        rdata[12:8] = claimed_id[4:0];
        rdata[0]    = state == CLAIMED;
      end
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state      <= IDLE;
      claimed_id <= '0;
    end else begin
      state      <= state_n;
      claimed_id <= claimed_n;
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      src_q     <= '0;
      primed    <= 1'b0;
      pending   <= '0;
      enable    <= '0;
      edge_mode <= '0;
      irq_o     <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
    end else begin
      src_q    <= irq_src_i;
      primed   <= 1'b1;
      irq_o    <= (state == IDLE) && |pe;
      wb_ack_o <= acc;
      if (acc) wb_data_o <= wb_we_i ? '0 : rdata;
      if (wr && idx == 3'd1) enable <= wmask;
      if (wr && idx == 3'd2) edge_mode <= wmask;
      for (int i = 0; i < N_SRC; i++)
        pending[i] <= edge_chg[i] ? 1'b0 : !edge_mode[i] ? irq_src_i[i] : set[i] ? 1'b1 : clr[i] ? 1'b0 : pending[i];
    end
endmodule

// File: tb/tb_wb_irq_ctrl.sv
// tb_wb_irq_ctrl: directed self-checking bench for wb_irq_ctrl
module tb_wb_irq_ctrl;
  logic clk = 0, rst = 1;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic we = 0, stb = 0, cyc = 0, ack, irq;
  logic [3:0] sel = 4'hf;
  logic [7:0] src = '0;
  logic [31:0] d;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  wb_irq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .wb_addr_i(addr), .wb_data_i(wdata), .wb_we_i(we),
    .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack), .wb_data_o(rdata),
    .irq_src_i(src), .irq_o(irq)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [2:0] r, input logic [31:0] v);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = {27'b0, r, 2'b0}; wdata = v;
    @(negedge clk);
    chk("wr_ack", {31'b0, ack}, 1);
    cyc = 0; stb = 0; we = 0;
  endtask
  task automatic rd(input logic [2:0] r, output logic [31:0] v);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; addr = {27'b0, r, 2'b0};
    @(negedge clk);
    chk("rd_ack", {31'b0, ack}, 1);
    v = rdata;
    cyc = 0; stb = 0;
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    cycles(2);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_ack", {31'b0, ack}, 0);
    rst = 0;
    // timer level flow
    wr(1, 32'h1);
    @(negedge clk); src = 8'h01;
    @(negedge clk); chk("lvl_irq_t1", {31'b0, irq}, 0);
    @(negedge clk); chk("lvl_irq_t2", {31'b0, irq}, 1);
    rd(3, d); chk("lvl_claim", d, 1);
    @(negedge clk); chk("lvl_irq_low", {31'b0, irq}, 0);
    src = 8'h00;
    cycles(2);
    wr(4, 32'h1);
    cycles(2); chk("lvl_irq_stay", {31'b0, irq}, 0);
    rd(5, d); chk("lvl_status", d, 0);
    // edge latch
    wr(2, 32'h4); wr(1, 32'h4);
    @(negedge clk); src = 8'h04;
    @(negedge clk); src = 8'h00;
    cycles(2);
    rd(0, d); chk("edge_pend", d, 32'h4);
    chk("edge_irq", {31'b0, irq}, 1);
    rd(3, d); chk("edge_claim", d, 3);
    rd(0, d); chk("edge_pend_clr", d, 0);
    wr(4, 32'h3);
    @(negedge clk);
    src = 8'h04; cyc = 1; stb = 1; we = 1; addr = 32'h0; wdata = 32'h4;
    @(negedge clk);
    src = 8'h00; chk("w1c_ack", {31'b0, ack}, 1); cyc = 0; stb = 0; we = 0;
    rd(0, d); chk("edge_set_wins", d, 32'h4);
    wr(0, 32'h4);
    rd(0, d); chk("edge_w1c", d, 0);
    // priority
    wr(2, 32'h0); wr(1, 32'h22);
    src = 8'h22;
    cycles(2);
    rd(3, d); chk("prio_claim", d, 2);
    src = 8'h20;
    wr(4, 32'h2);
    @(negedge clk); chk("prio_irq_re", {31'b0, irq}, 1);
    rd(3, d); chk("prio_claim2", d, 6);
    src = 8'h00;
    wr(4, 32'h6);
    // wrong complete
    wr(1, 32'h4); src = 8'h04;
    cycles(2);
    rd(3, d); chk("wc_claim", d, 3);
    rd(5, d); chk("wc_status", d, 32'h301);
    wr(4, 32'h4);
    rd(5, d); chk("wc_status_keep", d, 32'h301);
    chk("wc_irq", {31'b0, irq}, 0);
    src = 8'h00;
    wr(4, 32'h3);
    rd(5, d); chk("wc_status_clr", d, 0);
    // bus timing with cyc/stb held
    @(negedge clk); cyc = 1; stb = 1; we = 0; addr = 32'h1c;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_ack", {31'b0, ack}, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) chk("b2b_r7", rdata, 0);
    end
    cyc = 0; stb = 0;
    rd(6, d); chk("r6_zero", d, 0);
    // reset mid-claim with an access in flight
    wr(1, 32'h1); src = 8'h01;
    cycles(2);
    rd(3, d); chk("mc_claim", d, 1);
    @(negedge clk); cyc = 1; stb = 1; we = 0; addr = 32'h14;
    #2 rst = 1;
    #1 chk("mc_rst_irq", {31'b0, irq}, 0);
    @(negedge clk);
    chk("mc_rst_ack", {31'b0, ack}, 0);
    chk("mc_rst_data", rdata, 0);
    cyc = 0; stb = 0;
    rst = 0;
    rd(5, d); chk("mc_status", d, 0);
    rd(1, d); chk("mc_enable", d, 0);
    rd(3, d); chk("mc_claim0", d, 0);
    rd(0, d); chk("mc_lvl_pend", d, 1);
    chk("mc_irq", {31'b0, irq}, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
